// File: rtl/main_mem_arbiter.sv
// rtl/main_mem_arbiter.sv - round-robin two-requester arbiter for the main-memory port
// Latches the winning request, routes memory ready/data to the owner, aborts on watchdog expiry.
module main_mem_arbiter #(
    parameter int TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        reset,

    input  logic [31:0] rq0_rd_addr,
    input  logic        rq0_rd_valid,
    output logic [31:0] rq0_rd_data,
    output logic        rq0_rd_ready,
    input  logic [31:0] rq0_wr_addr,
    input  logic [31:0] rq0_wr_data,
    input  logic        rq0_wr_valid,
    output logic        rq0_wr_ready,

    input  logic [31:0] rq1_rd_addr,
    input  logic        rq1_rd_valid,
    output logic [31:0] rq1_rd_data,
    output logic        rq1_rd_ready,
    input  logic [31:0] rq1_wr_addr,
    input  logic [31:0] rq1_wr_data,
    input  logic        rq1_wr_valid,
    output logic        rq1_wr_ready,

    output logic [31:0] main_mem_in_addr,
    output logic [31:0] main_mem_in_data,
    output logic        main_mem_in_valid,
    input  logic        main_mem_in_ready,
    output logic [31:0] main_mem_out_addr,
    output logic        main_mem_out_valid,
    input  logic [31:0] main_mem_out_data,
    input  logic        main_mem_out_ready,

    output logic        busy,
    output logic        owner,
    output logic        timeout_err
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TMO = CW'(TIMEOUT);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic            last_grant_q, last_grant_d;
    logic            owner_q, owner_d;
    logic            op_wr_q, op_wr_d;
    logic [31:0]     addr_q, addr_d;
    logic [31:0]     data_q, data_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            timeout_err_q, timeout_err_d;

    logic            pend0, pend1, any_pend;
    logic            winner, win_wr;
    logic            mem_done, abort, done_pulse;

    always_comb begin
        pend0    = rq0_rd_valid | rq0_wr_valid;
        pend1    = rq1_rd_valid | rq1_wr_valid;
        any_pend = pend0 | pend1;
        // On a tie the requester that did not win last time goes next.
        winner   = (pend0 && pend1) ? ~last_grant_q : pend1;
        win_wr   = winner ? rq1_wr_valid : rq0_wr_valid;
        mem_done = (state_q == S_BUSY) &&
                   (op_wr_q ? main_mem_in_ready : main_mem_out_ready);
        abort    = (state_q == S_BUSY) && (TIMEOUT != 0) &&
                   (cnt_q == TMO) && !mem_done;
        done_pulse = mem_done | abort;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (any_pend) state_d = S_BUSY;
            S_BUSY: if (done_pulse) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        last_grant_d  = last_grant_q;
        owner_d       = owner_q;
        op_wr_d       = op_wr_q;
        addr_d        = addr_q;
        data_d        = data_q;
        cnt_d         = cnt_q;
        timeout_err_d = timeout_err_q | abort;
        if (state_q == S_IDLE) begin
            if (any_pend) begin
                owner_d      = winner;
                op_wr_d      = win_wr;
                last_grant_d = winner;
                cnt_d        = '0;
                if (winner) begin
                    addr_d = win_wr ? rq1_wr_addr : rq1_rd_addr;
                    if (win_wr) data_d = rq1_wr_data;
                end else begin
                    addr_d = win_wr ? rq0_wr_addr : rq0_rd_addr;
                    if (win_wr) data_d = rq0_wr_data;
                end
            end
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant_q  <= 1'b1;
            owner_q       <= 1'b0;
            op_wr_q       <= 1'b0;
            addr_q        <= '0;
            data_q        <= '0;
            cnt_q         <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            last_grant_q  <= last_grant_d;
            owner_q       <= owner_d;
            op_wr_q       <= op_wr_d;
            addr_q        <= addr_d;
            data_q        <= data_d;
            cnt_q         <= cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    always_comb begin
        busy               = (state_q == S_BUSY);
        owner              = owner_q;
        timeout_err        = timeout_err_q;
        main_mem_out_valid = busy & ~op_wr_q;
        main_mem_in_valid  = busy & op_wr_q;
        main_mem_out_addr  = addr_q;
        main_mem_in_addr   = addr_q;
        main_mem_in_data   = data_q;
        rq0_rd_ready       = done_pulse & ~owner_q & ~op_wr_q;
        rq0_wr_ready       = done_pulse & ~owner_q &  op_wr_q;
        rq1_rd_ready       = done_pulse &  owner_q & ~op_wr_q;
        rq1_wr_ready       = done_pulse &  owner_q &  op_wr_q;
        // An aborted read returns all-ones so the requester can tell it from real data.
        rq0_rd_data        = (abort & ~op_wr_q) ? 32'hffff_ffff : main_mem_out_data;
        rq1_rd_data        = rq0_rd_data;
    end

endmodule
